// File: rtl/pipe_hazard_tracker.sv
// Tracks destination/rf_en/load for the EX, MEM and WB stages of a 5-stage MIPS pipeline.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_destination,
  input  logic                  id_rf_enable,
  input  logic                  id_load_instruction,
  input  logic                  nop_signal,
  input  logic                  flush,
  input  logic                  mem_stall,
`ifdef PIPE_HAZARD_PERF_EN
  input  logic                  perf_clear,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      bubble_count,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      memstall_count,
  output logic [CNT_W-1:0]      retire_count,
`endif
  output logic [REG_ADDR_W-1:0] ex_destination,
  output logic [REG_ADDR_W-1:0] mem_destination,
  output logic [REG_ADDR_W-1:0] wb_destination,
  output logic                  ex_rf_enable,
  output logic                  mem_rf_enable,
  output logic                  wb_rf_enable,
  output logic                  ex_load_instruction,
  output logic                  mem_load_instruction,
  output logic                  wb_retire
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  rf_en;
    logic                  load;
  } entry_t;

  entry_t                ex_reg;
  entry_t                mem_reg;
  entry_t                id_entry;
  logic                  wb_valid_reg;
  logic [REG_ADDR_W-1:0] wb_dest_reg;
  logic                  wb_rf_reg;
  logic                  retire_reg;
  logic                  advance;
  logic                  insert_bubble;

  assign advance       = !mem_stall;
  assign insert_bubble = nop_signal | flush | !id_valid;

  // $zero must never look like a producer to the forwarding/stall logic.
  always_comb begin
    id_entry       = '0;
    id_entry.valid = id_valid;
    id_entry.dest  = id_destination;
    id_entry.rf_en = id_rf_enable & (id_destination != '0);
    id_entry.load  = id_load_instruction & (id_destination != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_reg       <= '0;
      mem_reg      <= '0;
      wb_valid_reg <= 1'b0;
      wb_dest_reg  <= '0;
      wb_rf_reg    <= 1'b0;
      retire_reg   <= 1'b0;
    end else if (advance) begin
      ex_reg       <= insert_bubble ? '0 : id_entry;
      mem_reg      <= ex_reg;
      wb_valid_reg <= mem_reg.valid;
      wb_dest_reg  <= mem_reg.dest;
      wb_rf_reg    <= mem_reg.rf_en;
      retire_reg   <= wb_valid_reg;
    end else begin
      retire_reg   <= 1'b0;
    end
  end

  assign ex_destination       = ex_reg.dest;
  assign ex_rf_enable         = ex_reg.rf_en;
  assign ex_load_instruction  = ex_reg.load;
  assign mem_destination      = mem_reg.dest;
  assign mem_rf_enable        = mem_reg.rf_en;
  assign mem_load_instruction = mem_reg.load;
  assign wb_destination       = wb_dest_reg;
  assign wb_rf_enable         = wb_rf_reg;
  assign wb_retire            = retire_reg;

`ifdef PIPE_HAZARD_PERF_EN
  localparam int N_CNT = 5;
  localparam int C_STALL = 0, C_BUBBLE = 1, C_FLUSH = 2, C_MEMSTALL = 3, C_RETIRE = 4;

  logic [N_CNT-1:0]            cnt_inc;
  logic [N_CNT-1:0][CNT_W-1:0] cnt_reg;

  // Retirements are counted on the same edge that raises wb_retire.
  always_comb begin
    cnt_inc             = '0;
    cnt_inc[C_STALL]    = advance & nop_signal & !flush;
    cnt_inc[C_BUBBLE]   = advance & insert_bubble;
    cnt_inc[C_FLUSH]    = advance & flush;
    cnt_inc[C_MEMSTALL] = mem_stall;
    cnt_inc[C_RETIRE]   = advance & wb_valid_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        if (perf_clear)
          cnt_reg[i] <= '0;
        else if (cnt_inc[i] && (cnt_reg[i] != {CNT_W{1'b1}}))
          cnt_reg[i] <= cnt_reg[i] + 1'b1;
      end
    end
  end

  assign stall_count    = cnt_reg[C_STALL];
  assign bubble_count   = cnt_reg[C_BUBBLE];
  assign flush_count    = cnt_reg[C_FLUSH];
  assign memstall_count = cnt_reg[C_MEMSTALL];
  assign retire_count   = cnt_reg[C_RETIRE];
`endif

endmodule

// File: doc/pipe_hazard_tracker.md
# pipe_hazard_tracker

- Tracks every in-flight instruction's destination register, register-write enable and load flag through the EX, MEM and WB stages of the 5-stage MIPS pipeline.
- Drives the `ex_/mem_/wb_destination`, `*_rf_enable` and `*_load_instruction` inputs of the hazard/forwarding unit.
- Consumes that unit's `nop_signal` to insert bubbles.
- Honours branch flush and data-memory stall, and optionally keeps performance counters for stalls, bubbles and retirements.

## Interface
Parameters:
- REG_ADDR_W, 5, register-file address width
- CNT_W, 32, width of each performance counter

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge
- reset_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID stage holds a real instruction
- id_destination  input  REG_ADDR_W  destination register of the ID instruction
- id_rf_enable  input  1  ID instruction writes the register file
- id_load_instruction  input  1  ID instruction is a load
- nop_signal  input  1  load-use stall from the hazard unit; insert a bubble into EX
- flush  input  1  taken branch/jump; kill the ID instruction
- mem_stall  input  1  data memory not ready; freeze all tracked stages
- perf_clear  input  1  synchronous clear of the counters (counter build only)
- ex_destination, mem_destination, wb_destination  output  REG_ADDR_W  stage destination registers
- ex_rf_enable, mem_rf_enable, wb_rf_enable  output  1  stage register-write enables
- ex_load_instruction, mem_load_instruction  output  1  stage holds a load
- wb_retire  output  1  one-cycle pulse when a valid instruction leaves WB
- stall_count, bubble_count, flush_count, memstall_count, retire_count  output  CNT_W  performance counters (counter build only)

## Operation
- Each of the EX, MEM and WB stages holds one entry: {valid, dest, rf_en, load}. A bubble is all fields 0.
- Entry admission from ID:
  - If `id_destination == 0`, the entry's rf_en and load are forced to 0, so register $zero never causes forwarding or a stall.
  - valid is set to `id_valid`.
- Advance cycle (`mem_stall == 0`):
  - WB <= MEM, MEM <= EX.
  - EX <= bubble if `nop_signal | flush | !id_valid`; otherwise EX <= admitted ID entry.
- Freeze cycle (`mem_stall == 1`): all three stages hold. `nop_signal` and `flush` are ignored that cycle; the hazard unit and front end re-present them.
- Priority: mem_stall > flush > nop_signal > normal admit.
- wb_retire is registered. It is 1 in the cycle after an advance in which WB held a valid entry.
- mem_load_instruction follows the MEM entry's load bit. WB has no load output.
- Outputs are direct register outputs with no combinational path from inputs.

## Timing
- ID -> EX latency: 1 cycle. EX -> MEM: 1 advance. MEM -> WB: 1 advance.
- Reset: asynchronous assertion clears all stage entries, wb_retire and every counter to 0 immediately, independent of clk. Reset mid-stall discards all held entries.
- Back-to-back `nop_signal` inserts one bubble per cycle.
- A held load in EX keeps `ex_load_instruction = 1` through any mem_stall.
- Counters, when built (each saturates at all-ones, no wrap; perf_clear overrides increments in the same cycle):
  - stall_count: +1 per advance cycle with `nop_signal & !flush`.
  - flush_count: +1 per advance cycle with flush.
  - bubble_count: +1 per advance cycle in which EX loads a bubble for any reason.
  - memstall_count: +1 per cycle with mem_stall.
  - retire_count: +1 per wb_retire pulse.

## Configuration
- `PIPE_HAZARD_PERF_EN` defined:
  - The perf_clear port and all five counter ports and counters exist.
- `PIPE_HAZARD_PERF_EN` undefined:
  - The perf_clear and counter ports are absent.
  - No counter logic is built.
  - Stage tracking and wb_retire are unchanged.

## Test plan
- Reset, then hold reset_n = 0 while driving valid IDs -> all outputs remain 0. Release -> first ID (dest 8, rf_en 1) appears on ex_destination = 8, ex_rf_enable = 1 one edge later.
- Stream dest 3, 4, 5 with `id_valid = 1` -> after 3 edges wb = 3, mem = 4, ex = 5. wb_retire first pulses one cycle after dest 3 leaves WB.
- Load to dest 7, then `nop_signal = 1` for one cycle -> ex_load = 1, then EX is a bubble (rf_en 0) while mem_load_instruction = 1 with mem = 7. stall_count = 1, bubble_count = 1.
- `mem_stall = 1` for 4 cycles with `nop_signal = 1` and `flush = 1` -> all stage outputs unchanged. memstall_count = 4, stall_count and flush_count unchanged.
- ID dest 0 with rf_en 1 and load 1 -> ex_rf_enable = 0, ex_load_instruction = 0. Entry still valid and later pulses wb_retire.
- Preload retire_count to all-ones (force), then retire one more -> count stays all-ones. Assert perf_clear together with a retire -> count = 0.
